// File: rtl/counter_updown_mod.sv
// N-bit up/down counter with programmable top value, wrap/saturate policy,
// enable prescaler, synchronous load, terminal-count pulse and sticky overflow.
module counter_updown_mod #(
  parameter int N        = 4,
  parameter int MAX      = 2**N-1,
  parameter int MODE     = 0,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] loadValue,
  input  logic [N-1:0] initValue,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         ovf
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [N-1:0]  MAX_V   = N'(MAX);
  localparam logic [PW-1:0] PH_LAST = PW'(PRESCALE-1);

  logic [PW-1:0] phase, phase_nxt;
  logic [N-1:0]  count_nxt;
  logic          tc_nxt, ovf_nxt;
  logic          step, at_bound;

  // Values above MAX are clamped so count never leaves 0..MAX.
  function automatic logic [N-1:0] clamp(input logic [N-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  always_comb begin
    phase_nxt = phase;
    count_nxt = count;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;
    step      = 1'b0;
    at_bound  = 1'b0;
    if (a) begin
      if (phase == PH_LAST) begin
        phase_nxt = '0;
        step      = 1'b1;
      end else begin
        phase_nxt = phase + 1'b1;
      end
    end
    if (step) begin
      at_bound = dir ? (count == MAX_V) : (count == '0);
      if (at_bound) begin
        tc_nxt  = 1'b1;
        ovf_nxt = 1'b1;
        if (MODE == 0) count_nxt = dir ? '0 : MAX_V;
      end else begin
        count_nxt = dir ? (count + 1'b1) : (count - 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= clamp(initValue);
      phase <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= clamp(loadValue);
      phase <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      phase <= phase_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: four parameterisations share one stimulus
// stream and are compared every cycle against an integer reference model.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       rst, load, a, dir;
  logic [3:0] lv, iv;

  logic [1:0] c0, c1, c2;
  logic [3:0] c3;
  logic [3:0] tcs, ovfs;

  int checks = 0;
  int errors = 0;

  // Instance parameters: N, MAX, MODE, PRESCALE
  int p_n[4], p_max[4], p_mode[4], p_pre[4];
  int m_cnt[4], m_ph[4], m_tc[4], m_ovf[4];

  always #5 clk = ~clk;

  counter_updown_mod #(.N(2), .MAX(3), .MODE(0), .PRESCALE(1)) u0 (
    .clk(clk), .rst(rst), .a(a), .dir(dir), .load(load),
    .loadValue(lv[1:0]), .initValue(iv[1:0]), .count(c0), .tc(tcs[0]), .ovf(ovfs[0]));
  counter_updown_mod #(.N(2), .MAX(3), .MODE(1), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .a(a), .dir(dir), .load(load),
    .loadValue(lv[1:0]), .initValue(iv[1:0]), .count(c1), .tc(tcs[1]), .ovf(ovfs[1]));
  counter_updown_mod #(.N(2), .MAX(2), .MODE(0), .PRESCALE(3)) u2 (
    .clk(clk), .rst(rst), .a(a), .dir(dir), .load(load),
    .loadValue(lv[1:0]), .initValue(iv[1:0]), .count(c2), .tc(tcs[2]), .ovf(ovfs[2]));
  counter_updown_mod #(.N(4), .MAX(9), .MODE(1), .PRESCALE(2)) u3 (
    .clk(clk), .rst(rst), .a(a), .dir(dir), .load(load),
    .loadValue(lv), .initValue(iv), .count(c3), .tc(tcs[3]), .ovf(ovfs[3]));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int obs_count(input int k);
    case (k)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  function automatic int min_int(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // Reference: apply the rules for one rising edge using plain integers.
  task automatic model_edge();
    int v;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        v = int'(iv) % (1 << p_n[k]);
        m_cnt[k] = min_int(v, p_max[k]);
        m_ph[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
      end else if (load) begin
        v = int'(lv) % (1 << p_n[k]);
        m_cnt[k] = min_int(v, p_max[k]);
        m_ph[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
      end else begin
        m_tc[k] = 0;
        if (a) begin
          m_ph[k] = m_ph[k] + 1;
          if (m_ph[k] == p_pre[k]) begin
            m_ph[k] = 0;
            if (dir && m_cnt[k] == p_max[k]) begin
              m_tc[k] = 1; m_ovf[k] = 1;
              m_cnt[k] = (p_mode[k] == 0) ? 0 : p_max[k];
            end else if (!dir && m_cnt[k] == 0) begin
              m_tc[k] = 1; m_ovf[k] = 1;
              m_cnt[k] = (p_mode[k] == 0) ? p_max[k] : 0;
            end else begin
              m_cnt[k] = dir ? m_cnt[k] + 1 : m_cnt[k] - 1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("count%0d", k), obs_count(k), m_cnt[k]);
      check($sformatf("tc%0d", k), int'(tcs[k]), m_tc[k]);
      check($sformatf("ovf%0d", k), int'(ovfs[k]), m_ovf[k]);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, compare 1 unit later.
  task automatic cycle(input logic nr, input logic nl, input logic na,
                       input logic nd, input logic [3:0] nlv, input logic [3:0] niv);
    rst = nr; load = nl; a = na; dir = nd; lv = nlv; iv = niv;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    p_n    = '{2, 2, 2, 4};
    p_max  = '{3, 3, 2, 9};
    p_mode = '{0, 1, 0, 1};
    p_pre  = '{1, 1, 3, 2};
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0; m_ph[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
    end
    rst = 1'b1; load = 1'b0; a = 1'b0; dir = 1'b0; lv = '0; iv = 4'd2;
    #1;

    // Reset held for several edges with initValue=2
    repeat (3) cycle(1, 0, 1, 1, 4'd0, 4'd2);
    cycle(0, 0, 0, 1, 4'd0, 4'd2);
    // Reset raised shortly before an edge must not act early
    #6;
    rst = 1'b1; iv = 4'd3;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
    check_all();

    // Wrap up from 2
    cycle(0, 1, 0, 1, 4'd2, 4'd3);
    repeat (3) cycle(0, 0, 1, 1, 4'd0, 4'd3);

    // Enable hold, then one enabled edge
    repeat (4) cycle(0, 0, 0, 1, 4'd0, 4'd3);
    cycle(0, 0, 1, 1, 4'd0, 4'd3);

    // Down from 1: saturate vs wrap
    cycle(0, 1, 0, 0, 4'd1, 4'd3);
    repeat (3) cycle(0, 0, 1, 0, 4'd0, 4'd3);

    // Load with clamp beats a step; reset beats load
    cycle(0, 1, 1, 1, 4'd3, 4'd3);
    cycle(0, 0, 1, 1, 4'd0, 4'd3);
    cycle(1, 1, 1, 1, 4'd1, 4'd3);
    cycle(1, 1, 1, 1, 4'd12, 4'd11);

    // Prescaler run from 0, then reset mid-phase
    cycle(0, 1, 0, 1, 4'd0, 4'd0);
    repeat (9) cycle(0, 0, 1, 1, 4'd0, 4'd0);
    cycle(0, 1, 0, 1, 4'd0, 4'd0);
    cycle(0, 0, 1, 1, 4'd0, 4'd0);
    cycle(1, 0, 1, 1, 4'd0, 4'd0);
    repeat (4) cycle(0, 0, 1, 1, 4'd0, 4'd0);
    // dir flip mid-phase keeps the phase
    cycle(0, 0, 1, 0, 4'd0, 4'd0);
    repeat (3) cycle(0, 0, 1, 1, 4'd0, 4'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
